// File: rtl/cu_param.sv
// Parametrised multi-cycle fetch/decode/execute sequencer with RAM wait states,
// resumable HALT and a wrapping retired-instruction counter.
module cu_param #(
    parameter int RS    = 2,
    parameter int CNT_W = 16,
    localparam int IW   = 4 + 2 * RS
) (
    input  logic             CU_clk,
    input  logic             CU_rst,
    input  logic [IW-1:0]    CU_in,
    input  logic             Mem_ready,
    input  logic             CU_resume,
    output logic [2:0]       Mode,
    output logic [RS-1:0]    Select,
    output logic [7:0]       State,
    output logic             Halted,
    output logic [CNT_W-1:0] Instr_count,
    output logic             MBR_rw,
    output logic             IR_rw,
    output logic             PC_inc,
    output logic             Reg_rw,
    output logic             Buff_rw,
    output logic             MAR_rw,
    output logic             RAM_rw,
    output logic             ALU_in_select,
    output logic             Reg_in_select,
    output logic             ALU_out_select,
    output logic             MAR_select,
    output logic             MBR_select,
    output logic             Data_imm,
    output logic             Buff_imm
);

    typedef enum logic [7:0] {
        FETCH_ADDR = 8'd0,
        FETCH_RD   = 8'd1,
        FETCH_IR   = 8'd2,
        DECODE     = 8'd3,
        LDST_ADDR  = 8'd4,
        MR_RD      = 8'd5,
        MI_WR      = 8'd6,
        ALU_RR     = 8'd7,
        ALU_IMM    = 8'd8,
        HALT       = 8'd9,
        MR_WR      = 8'd10,
        ALU_EXE    = 8'd11,
        ALU_WB     = 8'd12,
        LD_RD      = 8'd13,
        LD_WB      = 8'd14,
        ST_MBR     = 8'd15,
        ST_WR      = 8'd16
    } state_t;

    state_t           state;
    state_t           next;
    logic             retire;
    logic [CNT_W-1:0] count;
    logic [3:0]       opcode;
    logic [RS-1:0]    dst;
    logic [RS-1:0]    src;

    assign opcode      = CU_in[IW-1:IW-4];
    assign dst         = CU_in[2*RS-1:RS];
    assign src         = CU_in[RS-1:0];
    assign State       = state;
    assign Instr_count = count;

    always_ff @(posedge CU_clk) begin
        if (CU_rst) begin
            state <= FETCH_ADDR;
            count <= '0;
        end else begin
            state <= next;
            if (retire) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        next           = FETCH_ADDR;
        retire         = 1'b0;
        Mode           = 3'b111;
        Select         = '0;
        Halted         = 1'b0;
        MBR_rw         = 1'b0;
        IR_rw          = 1'b0;
        PC_inc         = 1'b0;
        Reg_rw         = 1'b0;
        Buff_rw        = 1'b0;
        MAR_rw         = 1'b0;
        RAM_rw         = 1'b0;
        ALU_in_select  = 1'b0;
        Reg_in_select  = 1'b0;
        ALU_out_select = 1'b0;
        MAR_select     = 1'b0;
        MBR_select     = 1'b0;
        Data_imm       = 1'b0;
        Buff_imm       = 1'b0;
        case (state)
            FETCH_ADDR: begin
                MAR_rw = 1'b1;
                next   = FETCH_RD;
            end
            FETCH_RD: begin
                MBR_rw = 1'b1;
                PC_inc = Mem_ready;
                next   = Mem_ready ? FETCH_IR : FETCH_RD;
            end
            FETCH_IR: begin
                IR_rw = 1'b1;
                next  = DECODE;
            end
            DECODE: begin
                case (opcode)
                    4'b0000, 4'b0001: next = LDST_ADDR;
                    // MR with both fields zero doubles as the HALT opcode
                    4'b0011: next = (dst == '0 && src == '0) ? HALT : MR_RD;
                    4'b0010: next = MI_WR;
                    4'b0100, 4'b0101, 4'b0111,
                    4'b0110, 4'b1000, 4'b1010: next = ALU_RR;
                    default: next = ALU_IMM;
                endcase
            end
            LDST_ADDR: begin
                MAR_rw     = 1'b1;
                MAR_select = 1'b1;
                next       = (opcode == 4'b0000) ? LD_RD : ST_MBR;
            end
            MR_RD: begin
                Buff_rw        = 1'b1;
                ALU_out_select = 1'b1;
                Select         = src;
                next           = MR_WR;
            end
            MI_WR: begin
                Data_imm = 1'b1;
                Reg_rw   = 1'b1;
                Select   = dst;
                retire   = 1'b1;
            end
            ALU_RR: begin
                Buff_rw        = 1'b1;
                ALU_out_select = 1'b1;
                Select         = src;
                next           = ALU_EXE;
            end
            ALU_IMM: begin
                Buff_rw  = 1'b1;
                Buff_imm = 1'b1;
                next     = ALU_EXE;
            end
            HALT: begin
                Halted = 1'b1;
                retire = CU_resume;
                next   = CU_resume ? FETCH_ADDR : HALT;
            end
            MR_WR: begin
                Reg_rw        = 1'b1;
                Reg_in_select = 1'b1;
                Select        = dst;
                retire        = 1'b1;
            end
            ALU_EXE: begin
                Buff_rw       = 1'b1;
                ALU_in_select = 1'b1;
                Select        = dst;
                case (opcode)
                    4'b0100, 4'b1100: Mode = 3'b000;
                    4'b0101, 4'b1101: Mode = 3'b001;
                    4'b0111, 4'b1111: Mode = 3'b010;
                    4'b0110, 4'b1110: Mode = 3'b011;
                    4'b1000, 4'b1001: Mode = 3'b100;
                    4'b1010, 4'b1011: Mode = 3'b101;
                    default:          Mode = 3'b111;
                endcase
                next = ALU_WB;
            end
            ALU_WB: begin
                Reg_rw        = 1'b1;
                Reg_in_select = 1'b1;
                Select        = dst;
                retire        = 1'b1;
            end
            LD_RD: begin
                MBR_rw = 1'b1;
                next   = Mem_ready ? LD_WB : LD_RD;
            end
            LD_WB: begin
                Reg_rw = 1'b1;
                retire = 1'b1;
            end
            ST_MBR: begin
                MBR_select = 1'b1;
                MBR_rw     = 1'b1;
                next       = ST_WR;
            end
            ST_WR: begin
                RAM_rw = 1'b1;
                retire = Mem_ready;
                next   = Mem_ready ? FETCH_ADDR : ST_WR;
            end
            default: next = FETCH_ADDR;
        endcase
        // Reset silences every output combinationally, not just on the next edge
        if (CU_rst) begin
            Mode           = 3'b111;
            Select         = '0;
            Halted         = 1'b0;
            MBR_rw         = 1'b0;
            IR_rw          = 1'b0;
            PC_inc         = 1'b0;
            Reg_rw         = 1'b0;
            Buff_rw        = 1'b0;
            MAR_rw         = 1'b0;
            RAM_rw         = 1'b0;
            ALU_in_select  = 1'b0;
            Reg_in_select  = 1'b0;
            ALU_out_select = 1'b0;
            MAR_select     = 1'b0;
            MBR_select     = 1'b0;
            Data_imm       = 1'b0;
            Buff_imm       = 1'b0;
        end
    end

endmodule
